// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - ARM B/BL condition evaluation, PC load, link write and flush sequencing
// Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int OFF_W        = 24,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_cond,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_off,
    input  logic              br_link,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              lr_we,
    output logic [ADDR_W-1:0] lr_data,
    output logic              flush,
    output logic              br_done,
    output logic              br_taken,
    output logic [3:0]        flags
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       not_taken_cnt
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, FLUSH} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          flags_q, eflags_q, cond_q;
    logic [ADDR_W-1:0]   pc_q, pc_target_q, lr_data_q;
    logic [OFF_W-1:0]    off_q;
    logic                link_q;
    logic                pc_load_q, lr_we_q, br_done_q, br_taken_q;
    logic                cond_ok;
    logic [ADDR_W-1:0]   off_ext;
    logic                accept;

    // flags layout: [3]=Z [2]=C [1]=N [0]=V
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v;
        z  = f[3];
        cy = f[2];
        n  = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = !cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cy & !z;
            4'b1001: cond_pass = !cy | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_ok  = cond_pass(cond_q, eflags_q);
    assign off_ext  = {{(ADDR_W-OFF_W){off_q[OFF_W-1]}}, off_q} << 2;
    assign br_ready = (state_q == IDLE) && !rst;
    assign accept   = br_valid && br_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (br_valid) state_d = EVAL;
            end
            EVAL: begin
                if (cond_ok && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES);
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flags_q     <= '0;
            eflags_q    <= '0;
            cond_q      <= '0;
            pc_q        <= '0;
            off_q       <= '0;
            link_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            lr_we_q     <= 1'b0;
            br_done_q   <= 1'b0;
            br_taken_q  <= 1'b0;
            pc_target_q <= '0;
            lr_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_load_q  <= 1'b0;
            lr_we_q    <= 1'b0;
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
            if (flags_we) flags_q <= flags_in;
            if (accept) begin
                cond_q   <= br_cond;
                pc_q     <= br_pc;
                off_q    <= br_off;
                link_q   <= br_link;
                // Same-cycle flag update is forwarded into the evaluation
                eflags_q <= flags_we ? flags_in : flags_q;
            end
            if (state_q == EVAL) begin
                br_done_q  <= 1'b1;
                br_taken_q <= cond_ok;
                pc_load_q  <= cond_ok;
                lr_we_q    <= cond_ok & link_q;
                if (cond_ok) pc_target_q <= pc_q + ADDR_W'(8) + off_ext;
                if (cond_ok & link_q) lr_data_q <= pc_q + ADDR_W'(4);
            end
        end
    end

    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
    assign lr_we     = lr_we_q;
    assign lr_data   = lr_data_q;
    assign br_done   = br_done_q;
    assign br_taken  = br_taken_q;
    assign flags     = flags_q;
    assign flush     = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, not_taken_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
        end else if (br_done_q) begin
            if (br_taken_q && taken_cnt_q != 16'hFFFF)
                taken_cnt_q <= taken_cnt_q + 16'd1;
            if (!br_taken_q && not_taken_cnt_q != 16'hFFFF)
                not_taken_cnt_q <= not_taken_cnt_q + 16'd1;
        end
    end

    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flags_we;
    logic [3:0]  flags_in;
    logic        br_valid;
    logic        br_ready;
    logic [3:0]  br_cond;
    logic [31:0] br_pc;
    logic [23:0] br_off;
    logic        br_link;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        lr_we;
    logic [31:0] lr_data;
    logic        flush;
    logic        br_done;
    logic        br_taken;
    logic [3:0]  flags;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, not_taken_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    branch_ctrl #(.ADDR_W(32), .OFF_W(24), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .flags_we(flags_we), .flags_in(flags_in),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_pc(br_pc), .br_off(br_off), .br_link(br_link),
        .pc_load(pc_load), .pc_target(pc_target), .lr_we(lr_we),
        .lr_data(lr_data), .flush(flush), .br_done(br_done),
        .br_taken(br_taken), .flags(flags)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_we = 1'b1;
        flags_in = f;
        tick();
        flags_we = 1'b0;
    endtask

    // Accept in cycle N; returns sampled in cycle N+2
    task automatic issue(input logic [3:0] c, input logic [31:0] pc,
                         input logic [23:0] off, input logic link);
        br_valid = 1'b1;
        br_cond  = c;
        br_pc    = pc;
        br_off   = off;
        br_link  = link;
        tick();
        br_valid = 1'b0;
        tick();
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!br_ready && k < 8) begin
            tick();
            k++;
        end
        n_total++;
        if (!br_ready) $display("FAIL wait_ready: br_ready=%0b required 1 within 8 cycles", br_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; flags_we = 1'b0; flags_in = 4'h0; br_valid = 1'b0;
        br_cond = 4'h0; br_pc = '0; br_off = '0; br_link = 1'b0;
        tick(); tick();
        n_total++;
        if ({br_ready, pc_load, lr_we, flush, br_done, br_taken} !== 6'b0)
            $display("FAIL reset_ctrl: got %b required 000000", {br_ready, pc_load, lr_we, flush, br_done, br_taken});
        else n_pass++;
        n_total++;
        if ({flags, pc_target, lr_data} !== 68'h0)
            $display("FAIL reset_data: flags=%h tgt=%h lr=%h required 0", flags, pc_target, lr_data);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if (br_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", br_ready);
        else n_pass++;
    endtask

    task automatic test_beq_taken();
        set_flags(4'b1000);
        n_total++;
        if (flags !== 4'b1000) $display("FAIL flags_write: got %b required 1000", flags);
        else n_pass++;
        issue(4'b0000, 32'h100, 24'h000002, 1'b0);
        n_total++;
        if ({br_done, br_taken, pc_load, lr_we, flush, br_ready} !== 6'b111010)
            $display("FAIL beq_n2: got %b required 111010", {br_done, br_taken, pc_load, lr_we, flush, br_ready});
        else n_pass++;
        n_total++;
        if (pc_target !== 32'h110) $display("FAIL beq_target: got %h required 00000110", pc_target);
        else n_pass++;
        tick();
        n_total++;
        if ({pc_load, br_done, flush, br_ready} !== 4'b0010)
            $display("FAIL beq_n3: got %b required 0010", {pc_load, br_done, flush, br_ready});
        else n_pass++;
        tick();
        n_total++;
        if ({flush, br_ready} !== 2'b01) $display("FAIL beq_n4: got %b required 01", {flush, br_ready});
        else n_pass++;
    endtask

    task automatic test_bne_not_taken();
        issue(4'b0001, 32'h200, 24'h000010, 1'b0);
        n_total++;
        if ({br_done, br_taken, pc_load, flush, br_ready} !== 5'b10001)
            $display("FAIL bne_n2: got %b required 10001", {br_done, br_taken, pc_load, flush, br_ready});
        else n_pass++;
        n_total++;
        if (pc_target !== 32'h110) $display("FAIL bne_target_hold: got %h required 00000110", pc_target);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        set_flags(4'b0000);
        flags_we = 1'b1; flags_in = 4'b0100;
        br_valid = 1'b1; br_cond = 4'b0010; br_pc = 32'h300; br_off = 24'h0; br_link = 1'b0;
        tick();
        flags_we = 1'b0; br_valid = 1'b0;
        n_total++;
        if (flags !== 4'b0100) $display("FAIL fwd_flags: got %b required 0100", flags);
        else n_pass++;
        tick();
        n_total++;
        if ({br_done, br_taken, pc_load} !== 3'b111 || pc_target !== 32'h308)
            $display("FAIL fwd_taken: got %b tgt=%h required 111 tgt=00000308", {br_done, br_taken, pc_load}, pc_target);
        else n_pass++;
        wait_ready();
    endtask

    task automatic test_bl_wrap();
        issue(4'b1110, 32'h4, 24'hFFFFFE, 1'b1);
        n_total++;
        if ({pc_load, lr_we} !== 2'b11) $display("FAIL bl_pulses: got %b required 11", {pc_load, lr_we});
        else n_pass++;
        n_total++;
        if (pc_target !== 32'h4 || lr_data !== 32'h8)
            $display("FAIL bl_values: tgt=%h lr=%h required 00000004 00000008", pc_target, lr_data);
        else n_pass++;
        tick();
        n_total++;
        if ({pc_load, lr_we} !== 2'b00) $display("FAIL bl_oneshot: got %b required 00", {pc_load, lr_we});
        else n_pass++;
        wait_ready();
        issue(4'b1110, 32'hFFFF_FFF8, 24'h000001, 1'b1);
        n_total++;
        if (pc_target !== 32'h4 || lr_data !== 32'hFFFF_FFFC)
            $display("FAIL bl_wrap: tgt=%h lr=%h required 00000004 fffffffc", pc_target, lr_data);
        else n_pass++;
        wait_ready();
    endtask

    task automatic test_signed_conds();
        logic [3:0] fl  [6] = '{4'b0011, 4'b0011, 4'b0010, 4'b1000, 4'b1000, 4'b1000};
        logic [3:0] cd  [6] = '{4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b1101, 4'b1111};
        logic       exp [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 6; i++) begin
            set_flags(fl[i]);
            issue(cd[i], 32'h1000, 24'h000004, 1'b0);
            n_total++;
            if (br_done !== 1'b1 || br_taken !== exp[i] || pc_load !== exp[i])
                $display("FAIL signed_%0d: done=%b taken=%b load=%b required 1 %b %b", i, br_done, br_taken, pc_load, exp[i], exp[i]);
            else n_pass++;
            wait_ready();
        end
    endtask

    task automatic test_reset_in_eval();
        br_valid = 1'b1; br_cond = 4'b1110; br_pc = 32'h500; br_off = 24'h1; br_link = 1'b1;
        tick();
        br_valid = 1'b0;
        rst = 1'b1;
        tick();
        n_total++;
        if ({pc_load, lr_we, br_done, br_ready} !== 4'b0000 || flags !== 4'b0000)
            $display("FAIL rst_eval: got %b flags=%b required 0000 flags=0000", {pc_load, lr_we, br_done, br_ready}, flags);
        else n_pass++;
        rst = 1'b0;
        tick();
        n_total++;
        if ({br_ready, flush, pc_load, lr_we} !== 4'b1000)
            $display("FAIL rst_eval_idle: got %b required 1000", {br_ready, flush, pc_load, lr_we});
        else n_pass++;
`ifdef BRANCH_STATS_EN
        n_total++;
        if (taken_cnt !== 16'd0 || not_taken_cnt !== 16'd0)
            $display("FAIL rst_stats: taken=%0d not_taken=%0d required 0 0", taken_cnt, not_taken_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_forwarding();
        test_bl_wrap();
        test_signed_conds();
        test_reset_in_eval();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
